xadac_vload: RTL

XADAC_VLOAD -- requirements
Module: xadac_vload

---
 rtl/xadac_pkg.sv | 72 +++++++
 rtl/xadac_if.sv | 33 +++
 rtl/xadac_vload.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/xadac_pkg.sv
// Shared types for the xadac accelerator port and the vector-load scoreboard.
// Element masking for partial-length vector loads lives here too.
package xadac_pkg;

  localparam int unsigned SbLen        = 4;
  localparam int unsigned IdWidth      = 2;
  localparam int unsigned AddrWidth    = 32;
  localparam int unsigned InstrWidth   = 32;
  localparam int unsigned RegWidth     = 32;
  localparam int unsigned VecElemWidth = 8;
  localparam int unsigned VecElems     = 16;
  localparam int unsigned VecDataWidth = VecElemWidth * VecElems;
  localparam int unsigned VecLenWidth  = 5;
  localparam int unsigned NumRs        = 2;
  localparam int unsigned NumVs        = 3;

  typedef logic [IdWidth-1:0]      IdT;
  typedef logic [AddrWidth-1:0]    AddrT;
  typedef logic [InstrWidth-1:0]   InstrT;
  typedef logic [RegWidth-1:0]     RegT;
  typedef logic [VecDataWidth-1:0] VecDataT;
  typedef logic [VecLenWidth-1:0]  VecLenT;

  typedef struct packed {
    IdT    id;
    InstrT instr;
  } dec_req_t;

  typedef struct packed {
    IdT               id;
    logic             accept;
    logic             vd_clobber;
    logic             rd_clobber;
    logic [NumRs-1:0] rs_read;
    logic [NumVs-1:0] vs_read;
  } dec_rsp_t;

  typedef struct packed {
    IdT               id;
    InstrT            instr;
    RegT [NumRs-1:0]  rs_data;
  } exe_req_t;

  typedef struct packed {
    IdT      id;
    RegT     rd_data;
    VecDataT vd_data;
  } exe_rsp_t;

  typedef struct packed {
    logic    busy;
    logic    ar_done;
    logic    r_done;
    logic    rsp_done;
    AddrT    addr;
    VecLenT  vlen;
    VecDataT data;
  } vload_entry_t;

  // Ones in every element below vlen; vlen beyond VecElems keeps the whole vector.
  function automatic VecDataT vload_elem_mask(input VecLenT vlen);
    VecDataT mask;
    mask = '0;
    for (int unsigned i = 0; i < VecElems; i++) begin
      if (i < 32'(vlen)) begin
        mask[i*VecElemWidth +: VecElemWidth] = '1;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/xadac_if.sv
// Decode/execute handshake bundle between a core and an xadac accelerator.
interface xadac_if;
  import xadac_pkg::*;

  logic     dec_req_valid;
  logic     dec_req_ready;
  dec_req_t dec_req;
  logic     dec_rsp_valid;
  logic     dec_rsp_ready;
  dec_rsp_t dec_rsp;

  logic     exe_req_valid;
  logic     exe_req_ready;
  exe_req_t exe_req;
  logic     exe_rsp_valid;
  logic     exe_rsp_ready;
  exe_rsp_t exe_rsp;

  modport slv (
    input  dec_req_valid, dec_req, dec_rsp_ready,
    input  exe_req_valid, exe_req, exe_rsp_ready,
    output dec_req_ready, dec_rsp_valid, dec_rsp,
    output exe_req_ready, exe_rsp_valid, exe_rsp
  );

  modport mst (
    output dec_req_valid, dec_req, dec_rsp_ready,
    output exe_req_valid, exe_req, exe_rsp_ready,
    input  dec_req_ready, dec_rsp_valid, dec_rsp,
    input  exe_req_ready, exe_rsp_valid, exe_rsp
  );

endinterface

// File: rtl/xadac_vload.sv
// Vector load unit: one AXI read per accepted instruction, tracked per id in a
// scoreboard so read data may return out of order.
module xadac_vload
  import xadac_pkg::*;
(
  input  logic    clk,
  input  logic    rstn,
  xadac_if.slv    slv,
  output IdT      axi_ar_id,
  output AddrT    axi_ar_addr,
  output logic    axi_ar_valid,
  input  logic    axi_ar_ready,
  input  IdT      axi_r_id,
  input  VecDataT axi_r_data,
  input  logic    axi_r_valid,
  output logic    axi_r_ready
);

  vload_entry_t [SbLen-1:0] sb_q, sb_d;

  logic     ar_valid_q, ar_valid_d;
  IdT       ar_id_q, ar_id_d;
  AddrT     ar_addr_q, ar_addr_d;
  logic     r_ready_q;
  logic     rsp_valid_q, rsp_valid_d;
  exe_rsp_t rsp_q, rsp_d;

  logic exe_hs, ar_hs, r_hs, r_hit, rsp_hs;
  logic ar_found, rsp_found;
  IdT   ar_idx, rsp_idx;

  // Decode is stateless: every instruction routed here is a vector load.
  assign slv.dec_rsp_valid = slv.dec_req_valid;
  assign slv.dec_req_ready = slv.dec_rsp_valid && slv.dec_rsp_ready;

  always_comb begin
    slv.dec_rsp            = '0;
    slv.dec_rsp.id         = slv.dec_req.id;
    slv.dec_rsp.accept     = 1'b1;
    slv.dec_rsp.vd_clobber = 1'b1;
    slv.dec_rsp.rd_clobber = 1'b0;
    slv.dec_rsp.rs_read    = 2'b01;
    slv.dec_rsp.vs_read    = '0;
  end

  assign slv.exe_req_ready = slv.exe_req_valid && !sb_q[slv.exe_req.id].busy;

  assign exe_hs = slv.exe_req_valid && slv.exe_req_ready;
  assign ar_hs  = ar_valid_q && axi_ar_ready;
  assign r_hs   = axi_r_valid && r_ready_q;
  assign r_hit  = sb_q[axi_r_id].ar_done && !sb_q[axi_r_id].r_done;
  assign rsp_hs = rsp_valid_q && slv.exe_rsp_ready;

  always_comb begin
    sb_d        = sb_q;
    ar_valid_d  = ar_valid_q;
    ar_id_d     = ar_id_q;
    ar_addr_d   = ar_addr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;
    ar_found    = 1'b0;
    ar_idx      = '0;
    rsp_found   = 1'b0;
    rsp_idx     = '0;

    if (rsp_hs) begin
      rsp_valid_d        = 1'b0;
      rsp_d              = '0;
      sb_d[rsp_q.id]     = '0;
    end

    if (exe_hs) begin
      sb_d[slv.exe_req.id].busy = 1'b1;
      sb_d[slv.exe_req.id].addr = slv.exe_req.rs_data[0];
      sb_d[slv.exe_req.id].vlen = slv.exe_req.instr[25 +: VecLenWidth];
    end

    // Beats for ids without an outstanding read are dropped.
    if (r_hs && r_hit) begin
      sb_d[axi_r_id].data   = axi_r_data;
      sb_d[axi_r_id].r_done = 1'b1;
    end

    if (ar_hs) begin
      ar_valid_d = 1'b0;
      ar_id_d    = '0;
      ar_addr_d  = '0;
    end

    // Picks see this cycle's updates so a fresh request issues next cycle.
    if (!ar_valid_d) begin
      for (int unsigned i = 0; i < SbLen; i++) begin
        if (!ar_found && sb_d[IdT'(i)].busy && !sb_d[IdT'(i)].ar_done) begin
          ar_found = 1'b1;
          ar_idx   = IdT'(i);
        end
      end
      if (ar_found) begin
        ar_valid_d           = 1'b1;
        ar_id_d              = ar_idx;
        ar_addr_d            = sb_d[ar_idx].addr;
        sb_d[ar_idx].ar_done = 1'b1;
      end
    end

    if (!rsp_valid_d) begin
      for (int unsigned i = 0; i < SbLen; i++) begin
        if (!rsp_found && sb_d[IdT'(i)].r_done && !sb_d[IdT'(i)].rsp_done) begin
          rsp_found = 1'b1;
          rsp_idx   = IdT'(i);
        end
      end
      if (rsp_found) begin
        rsp_valid_d             = 1'b1;
        rsp_d                   = '0;
        rsp_d.id                = rsp_idx;
        rsp_d.vd_data           = sb_d[rsp_idx].data & vload_elem_mask(sb_d[rsp_idx].vlen);
        sb_d[rsp_idx].rsp_done  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sb_q        <= '0;
      ar_valid_q  <= 1'b0;
      ar_id_q     <= '0;
      ar_addr_q   <= '0;
      r_ready_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      sb_q        <= sb_d;
      ar_valid_q  <= ar_valid_d;
      ar_id_q     <= ar_id_d;
      ar_addr_q   <= ar_addr_d;
      r_ready_q   <= 1'b1;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  assign axi_ar_valid      = ar_valid_q;
  assign axi_ar_id         = ar_id_q;
  assign axi_ar_addr       = ar_addr_q;
  assign axi_r_ready       = r_ready_q;
  assign slv.exe_rsp_valid = rsp_valid_q;
  assign slv.exe_rsp       = rsp_q;

  logic unused_in;
  assign unused_in = ^{slv.dec_req.instr, slv.exe_req.instr, slv.exe_req.rs_data[1]};

  assert property (@(posedge clk) disable iff (!rstn) r_hs |-> r_hit)
    else $warning("xadac_vload: dropped R beat for id %0d", axi_r_id);

endmodule
